// File: rtl/dcache_tid_tracker.sv
// Request-tag tracker between the core memory pipeline and the HPDC ports.
// Holds one IDLE/PENDING/KILLED entry per tag, caps outstanding requests and filters killed responses.
module dcache_tid_tracker #(
    parameter int TID_WIDTH    = 7,
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    input  logic [TID_WIDTH-1:0] req_tid_i,
    output logic                 req_ready_o,
    input  logic                 dcache_ready_i,
    output logic                 dcache_valid_o,
    input  logic                 rsp_valid_i,
    input  logic [TID_WIDTH-1:0] rsp_tid_i,
    output logic                 rsp_valid_o,
    input  logic                 kill_i,
    input  logic [TID_WIDTH-1:0] kill_tid_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] inflight_o,
    output logic                 full_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int NUM_TIDS = 2 ** TID_WIDTH;

    // Handshake: a request moves to the HPDC only when dcache_valid_o and dcache_ready_i
    // are both high in the same cycle; both outputs drop while the tag is owed or the table is full.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_KILLED  = 2'd2
    } tid_state_e;

    tid_state_e           tbl_q [NUM_TIDS];
    tid_state_e           tbl_d [NUM_TIDS];
    logic [CNT_WIDTH-1:0] inflight_q;
    logic [CNT_WIDTH-1:0] inflight_d;
    logic                 err_q;
    logic                 err_d;

    tid_state_e req_st;
    tid_state_e rsp_st;
    logic       stall;
    logic       send;
    logic       recv;
    logic       rsp_hit_idle;
    logic       send_killed;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_TIDS; i++) begin
                tbl_q[i] <= ST_IDLE;
            end
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TIDS; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Per-entry priority: receive beats kill/flush, which beats send.
    always_comb begin
        for (int i = 0; i < NUM_TIDS; i++) begin
            tbl_d[i] = tbl_q[i];
            if ((flush_i || (kill_i && kill_tid_i == TID_WIDTH'(i))) && tbl_q[i] == ST_PENDING) begin
                tbl_d[i] = ST_KILLED;
            end
            if (send && req_tid_i == TID_WIDTH'(i)) begin
                tbl_d[i] = send_killed ? ST_KILLED : ST_PENDING;
            end
            if (recv && rsp_tid_i == TID_WIDTH'(i)) begin
                tbl_d[i] = ST_IDLE;
            end
        end
        inflight_d = inflight_q + CNT_WIDTH'(send) - CNT_WIDTH'(recv);
        err_d      = err_q | rsp_hit_idle;
    end

    always_comb begin
        req_st         = tbl_q[req_tid_i];
        rsp_st         = tbl_q[rsp_tid_i];
        inflight_o     = inflight_q;
        err_o          = err_q;
        full_o         = (inflight_q == CNT_WIDTH'(MAX_INFLIGHT));
        idle_o         = (inflight_q == '0);
        stall          = (req_st != ST_IDLE) | full_o;
        dcache_valid_o = req_valid_i & ~stall;
        req_ready_o    = dcache_ready_i & ~stall;
        send           = dcache_valid_o & dcache_ready_i;
        send_killed    = flush_i | (kill_i & (kill_tid_i == req_tid_i));
        recv           = rsp_valid_i & (rsp_st != ST_IDLE);
        rsp_hit_idle   = rsp_valid_i & (rsp_st == ST_IDLE);
        rsp_valid_o    = rsp_valid_i & (rsp_st == ST_PENDING)
                       & ~(kill_i & (kill_tid_i == rsp_tid_i)) & ~flush_i;
    end

endmodule

// File: tb/tb_dcache_tid_tracker.sv
// Directed bench for dcache_tid_tracker with a small per-tag delivery model
// feeding an expected-response queue.
module tb_dcache_tid_tracker;

    localparam int TID_WIDTH    = 7;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1);
    localparam int NUM_TIDS     = 2 ** TID_WIDTH;

    logic                 clk_i;
    logic                 rstn_i;
    logic                 req_valid_i;
    logic [TID_WIDTH-1:0] req_tid_i;
    logic                 req_ready_o;
    logic                 dcache_ready_i;
    logic                 dcache_valid_o;
    logic                 rsp_valid_i;
    logic [TID_WIDTH-1:0] rsp_tid_i;
    logic                 rsp_valid_o;
    logic                 kill_i;
    logic [TID_WIDTH-1:0] kill_tid_i;
    logic                 flush_i;
    logic [CNT_WIDTH-1:0] inflight_o;
    logic                 full_o;
    logic                 idle_o;
    logic                 err_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    logic exp_deliver [NUM_TIDS];

    dcache_tid_tracker #(
        .TID_WIDTH   (TID_WIDTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_tid_i     (req_tid_i),
        .req_ready_o   (req_ready_o),
        .dcache_ready_i(dcache_ready_i),
        .dcache_valid_o(dcache_valid_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_tid_i     (rsp_tid_i),
        .rsp_valid_o   (rsp_valid_o),
        .kill_i        (kill_i),
        .kill_tid_i    (kill_tid_i),
        .flush_i       (flush_i),
        .inflight_o    (inflight_o),
        .full_o        (full_o),
        .idle_o        (idle_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_TIDS; i++) exp_deliver[i] = 1'b0;
        exp_q.delete();
    endtask

    // Sends one request that must be accepted immediately.
    task automatic send_req(input int t);
        req_valid_i    = 1'b1;
        req_tid_i      = TID_WIDTH'(t);
        dcache_ready_i = 1'b1;
        @(negedge clk_i);
        chk("send_dcache_valid", dcache_valid_o, 1);
        chk("send_req_ready", req_ready_o, 1);
        exp_deliver[t] = 1'b1;
        tick();
        req_valid_i    = 1'b0;
        dcache_ready_i = 1'b0;
    endtask

    task automatic start_rsp(input int t);
        rsp_valid_i = 1'b1;
        rsp_tid_i   = TID_WIDTH'(t);
        exp_q.push_back(exp_deliver[t]);
        exp_deliver[t] = 1'b0;
    endtask

    task automatic check_rsp();
        logic e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_queue observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            chk("rsp_valid_o", rsp_valid_o, e);
        end
    endtask

    task automatic rsp(input int t);
        start_rsp(t);
        @(negedge clk_i);
        check_rsp();
        tick();
        rsp_valid_i = 1'b0;
    endtask

    initial begin
        rstn_i = 1'b0; req_valid_i = 1'b0; req_tid_i = '0; dcache_ready_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_tid_i = '0; kill_i = 1'b0; kill_tid_i = '0; flush_i = 1'b0;
        clear_model();
        repeat (3) tick();
        rstn_i = 1'b1;
        tick();

        // Reset state
        chk("rst_inflight", inflight_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_err", err_o, 0);

        // Basic send / response on tid 5
        send_req(5);
        chk("t5_inflight_1", inflight_o, 1);
        chk("t5_idle_0", idle_o, 0);
        tick();
        rsp(5);
        chk("t5_inflight_0", inflight_o, 0);
        chk("t5_idle_1", idle_o, 1);

        // Tag reuse stall on tid 3
        send_req(3);
        req_valid_i = 1'b1; req_tid_i = 7'd3; dcache_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t3_reuse_dv", dcache_valid_o, 0);
        chk("t3_reuse_rdy", req_ready_o, 0);
        tick();
        start_rsp(3);
        @(negedge clk_i);
        check_rsp();
        chk("t3_rsp_cycle_dv", dcache_valid_o, 0);
        tick();
        rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t3_after_rsp_dv", dcache_valid_o, 1);
        exp_deliver[3] = 1'b1;
        tick();
        req_valid_i = 1'b0; dcache_ready_i = 1'b0;
        chk("t3_resend_inflight", inflight_o, 1);
        rsp(3);
        chk("t3_drain_inflight", inflight_o, 0);

        // Cap at MAX_INFLIGHT
        for (int t = 0; t < 4; t++) send_req(t);
        chk("cap_full", full_o, 1);
        chk("cap_inflight", inflight_o, 4);
        req_valid_i = 1'b1; req_tid_i = 7'd4; dcache_ready_i = 1'b1;
        start_rsp(1);
        @(negedge clk_i);
        check_rsp();
        chk("cap_stall_dv", dcache_valid_o, 0);
        chk("cap_stall_rdy", req_ready_o, 0);
        tick();
        rsp_valid_i = 1'b0;
        chk("cap_after_rsp_full", full_o, 0);
        @(negedge clk_i);
        chk("cap_t4_dv", dcache_valid_o, 1);
        exp_deliver[4] = 1'b1;
        tick();
        req_valid_i = 1'b0; dcache_ready_i = 1'b0;
        chk("cap_inflight_4", inflight_o, 4);
        chk("cap_full_again", full_o, 1);
        rsp(0); rsp(2); rsp(3); rsp(4);
        chk("cap_drained_idle", idle_o, 1);

        // Kill of a pending tag
        send_req(9);
        kill_i = 1'b1; kill_tid_i = 7'd9; exp_deliver[9] = 1'b0;
        tick();
        kill_i = 1'b0;
        chk("kill_inflight_kept", inflight_o, 1);
        tick();
        rsp(9);
        chk("kill_inflight_0", inflight_o, 0);
        chk("kill_err_0", err_o, 0);
        req_valid_i = 1'b1; req_tid_i = 7'd9;
        @(negedge clk_i);
        chk("kill_entry_idle", dcache_valid_o, 1);
        req_valid_i = 1'b0;
        tick();

        // Kill on an idle tag is a no-op
        kill_i = 1'b1; kill_tid_i = 7'd30;
        tick();
        kill_i = 1'b0;
        chk("kill_idle_noop", inflight_o, 0);

        // Kill in the same cycle as the send
        req_valid_i = 1'b1; req_tid_i = 7'd40; dcache_ready_i = 1'b1;
        kill_i = 1'b1; kill_tid_i = 7'd40;
        tick();
        req_valid_i = 1'b0; dcache_ready_i = 1'b0; kill_i = 1'b0;
        chk("kill_send_inflight", inflight_o, 1);
        rsp(40);
        chk("kill_send_drained", inflight_o, 0);

        // Same-cycle kill and response: response suppressed, entry freed
        send_req(20);
        exp_deliver[20] = 1'b0;
        kill_i = 1'b1; kill_tid_i = 7'd20;
        rsp(20);
        kill_i = 1'b0;
        chk("kill_rsp_inflight", inflight_o, 0);
        chk("kill_rsp_err", err_o, 0);

        // Flush of three pending tags
        send_req(1); send_req(2); send_req(7);
        flush_i = 1'b1;
        exp_deliver[1] = 1'b0; exp_deliver[2] = 1'b0; exp_deliver[7] = 1'b0;
        tick();
        flush_i = 1'b0;
        chk("flush_inflight", inflight_o, 3);
        rsp(1);
        rsp(2);
        chk("flush_not_idle", idle_o, 0);
        rsp(7);
        chk("flush_idle", idle_o, 1);

        // Unsolicited response sets sticky error; async reset clears mid-cycle
        send_req(50);
        rsp(12);
        chk("err_inflight_kept", inflight_o, 1);
        chk("err_set", err_o, 1);
        repeat (3) tick();
        chk("err_sticky", err_o, 1);
        rstn_i = 1'b0;
        #2;
        chk("async_rst_err", err_o, 0);
        chk("async_rst_inflight", inflight_o, 0);
        clear_model();
        tick();
        rstn_i = 1'b1;
        tick();
        rsp(50);
        chk("stale_rsp_err", err_o, 1);
        chk("stale_rsp_inflight", inflight_o, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_tid_tracker.md
Name: dcache_tid_tracker

Overview:
- Parametrised tag/transaction tracker between the core memory pipeline and the HPDC request/response ports.
- Holds one state entry per request tag (tid). Stalls reuse of a tag while a response is still owed, and caps total outstanding requests.
- Drops responses belonging to killed requests, supports per-tag kill of in-flight requests and global flush, and exposes drain/occupancy status for fences and the PMU.

Parameters:
- TID_WIDTH, 7: request tag width; the table has 2**TID_WIDTH entries.
- MAX_INFLIGHT, 16: max outstanding requests, 1 ≤ MAX_INFLIGHT ≤ 2**TID_WIDTH.
- CNT_WIDTH, $clog2(MAX_INFLIGHT+1): derived; width of inflight_o.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  core request valid
- req_tid_i  in  TID_WIDTH  core request tag
- req_ready_o  out  1  core may hand over request this cycle
- dcache_ready_i  in  1  HPDC accepts request
- dcache_valid_o  out  1  request valid towards HPDC
- rsp_valid_i  in  1  HPDC response valid
- rsp_tid_i  in  TID_WIDTH  HPDC response tag
- rsp_valid_o  out  1  filtered response valid to core
- kill_i  in  1  kill one request
- kill_tid_i  in  TID_WIDTH  tag to kill
- flush_i  in  1  kill every outstanding request
- inflight_o  out  CNT_WIDTH  responses owed (PENDING+KILLED)
- full_o  out  1  inflight_o == MAX_INFLIGHT
- idle_o  out  1  inflight_o == 0
- err_o  out  1  sticky protocol error

Behaviour:
- Per-tag state, 2 bits: IDLE, PENDING, KILLED. Reset: all entries IDLE, inflight 0, err_o 0. After reset, full_o=0 and idle_o=1.
- Reset is asynchronous and takes effect mid-operation. A response arriving after reset for a pre-reset tag hits an IDLE entry and sets err_o.
- stall = (table[req_tid_i] != IDLE) | full_o.
- dcache_valid_o = req_valid_i & ~stall. req_ready_o = dcache_ready_i & ~stall. Both are combinational and have zero latency.
- send = dcache_valid_o & dcache_ready_i. On send: table[req_tid_i] <= PENDING next cycle.
- Response handling, where st = table[rsp_tid_i] before update:
  - rsp_valid_o = rsp_valid_i & st==PENDING & ~(kill_i & kill_tid_i==rsp_tid_i) & ~flush_i. This is combinational, so a same-cycle kill or flush suppresses delivery.
  - rsp_valid_i with st != IDLE: entry <= IDLE. This counts as a receive.
  - rsp_valid_i with st == IDLE: entry unchanged, no receive, err_o <= 1.
- Kill, when kill_i is high:
  - If the entry is PENDING, it becomes KILLED.
  - If a send has the same tid this cycle, the entry becomes KILLED instead of PENDING.
  - If the entry is IDLE and there is no same-cycle send, kill is a no-op. It does not change the counter.
  - If a response on the same tid arrives this cycle, the response wins: the entry becomes IDLE.
- Flush, when flush_i is high:
  - Every PENDING entry becomes KILLED, and a same-cycle send enters KILLED.
  - A same-cycle receive still makes its entry IDLE.
- Counter: inflight <= inflight + send - receive, computed as a single update so simultaneous send and receive leave it unchanged. Kill and flush never change the counter.
- Priority per entry: receive > (kill|flush) > send.
- err_o is cleared only by reset.
- Tags of different entries are independent. A send and a receive on different tids in the same cycle both apply.

Test Plan:
- Reset, then send tid 5; response tid 5 two cycles later -> rsp_valid_o=1 that cycle; inflight_o goes 0→1→0; idle_o back to 1.
- Send tid 3; while it is pending, present req tid 3 -> dcache_valid_o=0 and req_ready_o=0. After the tid 3 response, the next cycle has dcache_valid_o=1.
- MAX_INFLIGHT=4: send tids 0..3 -> full_o=1; tid 4 is stalled. A response on tid 1 in the same cycle as req tid 4 keeps tid 4 stalled; tid 4 is accepted the next cycle, and inflight_o stays 4.
- Send tid 9, then kill_i with kill_tid_i=9; later response tid 9 -> rsp_valid_o=0, entry IDLE, inflight_o drops by 1, err_o=0.
- Send tids 1,2,7, then flush_i for one cycle -> all three responses suppressed; idle_o=1 after the third response.
- Response tid 12 with no prior request -> rsp_valid_o=0, inflight_o unchanged, err_o=1 and held until rstn_i is asserted low.
